tge_tx_pkt_gen: RTL and testbench

TGE_TX_PKT_GEN -- requirements
Module: tge_tx_pkt_gen

---
 rtl/tge_tx_pkt_gen.sv | 120 ++++++++++++
 tb/tb_tge_tx_pkt_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tge_tx_pkt_gen.sv
// 10GbE TX test packet generator: emits fixed-length packets of 64-bit sequence/index
// words, with a programmable inter-packet gap and packet count, under core back-pressure.
module tge_tx_pkt_gen #(
  parameter logic [31:0] DEST_IP   = {8'd192, 8'd168, 8'd43, 8'd41},
  parameter logic [15:0] DEST_PORT = 16'h6666
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [11:0] pkt_len,
  input  logic [15:0] gap,
  input  logic [31:0] pkt_count_max,
  input  logic        tx_afull,
  input  logic        tx_overflow,
  output logic        tx_valid,
  output logic        tx_end_of_frame,
  output logic [63:0] tx_data,
  output logic [31:0] tx_dest_ip,
  output logic [15:0] tx_dest_port,
  output logic        busy,
  output logic        done,
  output logic [31:0] pkts_sent,
  output logic        overflow_seen
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t      state, state_nxt;
  logic [11:0] len_q;
  logic [15:0] gap_q;
  logic [31:0] cnt_max_q;
  logic [11:0] word_idx;
  logic [31:0] seq;
  logic [15:0] gap_cnt;
  logic        start, send_word, last_word;

  assign tx_dest_ip   = DEST_IP;
  assign tx_dest_port = DEST_PORT;
  assign busy         = (state == SEND) || (state == GAP);
  assign done         = (state == DONE);

  assign start     = (state == IDLE) && en && (pkt_len != 12'd0);
  assign send_word = (state == SEND) && !tx_afull;
  assign last_word = send_word && (word_idx == len_q - 12'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: begin
        // A packet in flight always finishes; the exit decision happens on its eof word.
        if (last_word) begin
          if ((cnt_max_q != 32'd0) && (pkts_sent + 32'd1 == cnt_max_q)) state_nxt = DONE;
          else if (!en)                                                  state_nxt = IDLE;
          else if (gap_q != 16'd0)                                       state_nxt = GAP;
          else                                                           state_nxt = SEND;
        end
      end
      GAP: begin
        if (!en)                    state_nxt = IDLE;
        else if (gap_cnt == 16'd0)  state_nxt = SEND;
      end
      DONE: if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      len_q         <= 12'd0;
      gap_q         <= 16'd0;
      cnt_max_q     <= 32'd0;
      word_idx      <= 12'd0;
      seq           <= 32'd0;
      gap_cnt       <= 16'd0;
      pkts_sent     <= 32'd0;
      overflow_seen <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        len_q         <= pkt_len;
        gap_q         <= gap;
        cnt_max_q     <= pkt_count_max;
        word_idx      <= 12'd0;
        seq           <= 32'd0;
        pkts_sent     <= 32'd0;
        overflow_seen <= 1'b0;
      end
      if (send_word) word_idx <= last_word ? 12'd0 : word_idx + 12'd1;
      if (last_word) begin
        seq       <= seq + 32'd1;
        pkts_sent <= pkts_sent + 32'd1;
        // Entering GAP counts down gap-1..0, giving exactly gap idle cycles.
        gap_cnt   <= gap_q - 16'd1;
      end else if ((state == GAP) && (gap_cnt != 16'd0)) begin
        gap_cnt <= gap_cnt - 16'd1;
      end
      if (tx_overflow) overflow_seen <= 1'b1;
    end
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_data         <= 64'd0;
    end else if (send_word) begin
      tx_valid        <= 1'b1;
      tx_end_of_frame <= last_word;
      tx_data         <= {seq, 20'd0, word_idx};
    end else begin
      tx_valid        <= 1'b0;
      tx_end_of_frame <= 1'b0;
      tx_data         <= 64'd0;
    end
  end

endmodule

// File: tb/tb_tge_tx_pkt_gen.sv
// Directed bench for tge_tx_pkt_gen: packet framing, gap, back-pressure, en drop,
// single-word packets, mid-packet reset and the sticky overflow flag.
module tb_tge_tx_pkt_gen;

  logic        clk = 1'b0;
  logic        rst, en, tx_afull, tx_overflow;
  logic [11:0] pkt_len;
  logic [15:0] gap;
  logic [31:0] pkt_count_max;
  logic        tx_valid, tx_end_of_frame, busy, done, overflow_seen;
  logic [63:0] tx_data;
  logic [31:0] tx_dest_ip, pkts_sent;
  logic [15:0] tx_dest_port;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tge_tx_pkt_gen dut (
    .clk(clk), .rst(rst), .en(en), .pkt_len(pkt_len), .gap(gap),
    .pkt_count_max(pkt_count_max), .tx_afull(tx_afull), .tx_overflow(tx_overflow),
    .tx_valid(tx_valid), .tx_end_of_frame(tx_end_of_frame), .tx_data(tx_data),
    .tx_dest_ip(tx_dest_ip), .tx_dest_port(tx_dest_port), .busy(busy), .done(done),
    .pkts_sent(pkts_sent), .overflow_seen(overflow_seen)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the word registered on the most recent edge.
  task automatic expw(input string tag, input logic v, input logic eof,
                      input logic [31:0] s, input logic [11:0] idx);
    chk({tag, ".valid"}, {63'd0, tx_valid}, {63'd0, v});
    chk({tag, ".eof"}, {63'd0, tx_end_of_frame}, {63'd0, eof});
    if (v) chk({tag, ".data"}, tx_data, {s, 20'd0, idx});
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tx_afull = 1'b0; tx_overflow = 1'b0;
    pkt_len = 12'd4; gap = 16'd2; pkt_count_max = 32'd2;
    step();
    step();
    chk("rst.valid", {63'd0, tx_valid}, 64'd0);
    chk("rst.eof", {63'd0, tx_end_of_frame}, 64'd0);
    chk("rst.data", tx_data, 64'd0);
    chk("rst.busy", {63'd0, busy}, 64'd0);
    chk("rst.done", {63'd0, done}, 64'd0);
    chk("rst.pkts", {32'd0, pkts_sent}, 64'd0);
    chk("rst.ovf", {63'd0, overflow_seen}, 64'd0);
    chk("dest_ip", {32'd0, tx_dest_ip}, {32'd0, 8'd192, 8'd168, 8'd43, 8'd41});
    chk("dest_port", {48'd0, tx_dest_port}, 64'h6666);

    // len=4, gap=2, count=2
    rst = 1'b0; en = 1'b1;
    step();
    expw("t1.lat", 1'b0, 1'b0, 32'd0, 12'd0);
    chk("t1.busy", {63'd0, busy}, 64'd1);
    step(); expw("t1.w0", 1'b1, 1'b0, 32'd0, 12'd0);
    step(); expw("t1.w1", 1'b1, 1'b0, 32'd0, 12'd1);
    step(); expw("t1.w2", 1'b1, 1'b0, 32'd0, 12'd2);
    step(); expw("t1.w3", 1'b1, 1'b1, 32'd0, 12'd3);
    chk("t1.pkts1", {32'd0, pkts_sent}, 64'd1);
    step(); expw("t1.g0", 1'b0, 1'b0, 32'd0, 12'd0);
    step(); expw("t1.g1", 1'b0, 1'b0, 32'd0, 12'd0);
    step(); expw("t1.p1w0", 1'b1, 1'b0, 32'd1, 12'd0);
    step(); expw("t1.p1w1", 1'b1, 1'b0, 32'd1, 12'd1);
    step(); expw("t1.p1w2", 1'b1, 1'b0, 32'd1, 12'd2);
    step(); expw("t1.p1w3", 1'b1, 1'b1, 32'd1, 12'd3);
    step();
    expw("t1.idle", 1'b0, 1'b0, 32'd0, 12'd0);
    chk("t1.done", {63'd0, done}, 64'd1);
    chk("t1.busy_d", {63'd0, busy}, 64'd0);
    chk("t1.pkts2", {32'd0, pkts_sent}, 64'd2);
    en = 1'b0;
    step();
    chk("t1.undone", {63'd0, done}, 64'd0);
    chk("t1.hold", {32'd0, pkts_sent}, 64'd2);

    // len=8 with three cycles of back-pressure after word 2
    pkt_len = 12'd8; gap = 16'd0; pkt_count_max = 32'd1; en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step(); expw($sformatf("t2.w%0d", i), 1'b1, 1'b0, 32'd0, 12'(i));
    end
    tx_afull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expw($sformatf("t2.af%0d", i), 1'b0, 1'b0, 32'd0, 12'd0);
    end
    tx_afull = 1'b0;
    for (int i = 3; i < 8; i++) begin
      step(); expw($sformatf("t2.w%0d", i), 1'b1, i == 7, 32'd0, 12'(i));
    end
    step();
    chk("t2.done", {63'd0, done}, 64'd1);
    chk("t2.pkts", {32'd0, pkts_sent}, 64'd1);
    en = 1'b0;
    step();

    // en dropped after word 1; pkt_len change mid-run must be ignored
    pkt_len = 12'd8; pkt_count_max = 32'd0; en = 1'b1;
    step();
    step(); expw("t3.w0", 1'b1, 1'b0, 32'd0, 12'd0);
    step(); expw("t3.w1", 1'b1, 1'b0, 32'd0, 12'd1);
    en = 1'b0; pkt_len = 12'd2;
    for (int i = 2; i < 8; i++) begin
      step(); expw($sformatf("t3.w%0d", i), 1'b1, i == 7, 32'd0, 12'(i));
    end
    chk("t3.busy", {63'd0, busy}, 64'd0);
    chk("t3.pkts", {32'd0, pkts_sent}, 64'd1);
    step(); expw("t3.idle", 1'b0, 1'b0, 32'd0, 12'd0);

    // single-word packets back to back
    pkt_len = 12'd1; gap = 16'd0; pkt_count_max = 32'd3; en = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step(); expw($sformatf("t4.p%0d", i), 1'b1, 1'b1, 32'(i), 12'd0);
    end
    step();
    expw("t4.idle", 1'b0, 1'b0, 32'd0, 12'd0);
    chk("t4.done", {63'd0, done}, 64'd1);
    chk("t4.pkts", {32'd0, pkts_sent}, 64'd3);
    en = 1'b0;
    step();

    // reset at word 2 of 4, then restart from seq 0
    pkt_len = 12'd4; pkt_count_max = 32'd0; en = 1'b1;
    step();
    step(); expw("t5.w0", 1'b1, 1'b0, 32'd0, 12'd0);
    step(); expw("t5.w1", 1'b1, 1'b0, 32'd0, 12'd1);
    step(); expw("t5.w2", 1'b1, 1'b0, 32'd0, 12'd2);
    rst = 1'b1;
    step();
    expw("t5.rst", 1'b0, 1'b0, 32'd0, 12'd0);
    chk("t5.data", tx_data, 64'd0);
    chk("t5.busy", {63'd0, busy}, 64'd0);
    chk("t5.pkts", {32'd0, pkts_sent}, 64'd0);
    rst = 1'b0;
    step();
    step(); expw("t5.re0", 1'b1, 1'b0, 32'd0, 12'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // overflow pulse mid-packet, sticky through DONE, cleared by a new run
    pkt_len = 12'd2; pkt_count_max = 32'd1; en = 1'b1;
    step();
    tx_overflow = 1'b1;
    step(); expw("t6.w0", 1'b1, 1'b0, 32'd0, 12'd0);
    tx_overflow = 1'b0;
    chk("t6.ovf", {63'd0, overflow_seen}, 64'd1);
    step(); expw("t6.w1", 1'b1, 1'b1, 32'd0, 12'd1);
    step();
    chk("t6.done", {63'd0, done}, 64'd1);
    chk("t6.ovf_done", {63'd0, overflow_seen}, 64'd1);
    en = 1'b0;
    step();
    chk("t6.ovf_idle", {63'd0, overflow_seen}, 64'd1);
    en = 1'b1;
    step();
    chk("t6.ovf_clr", {63'd0, overflow_seen}, 64'd0);
    chk("t6.pkts_clr", {32'd0, pkts_sent}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
